seed_lfsr_stream_bank: RTL

//   Parametrised latent-seed source for the generator. Produces a deterministic
//   Q8.8 latent vector from a programmable-tap Fibonacci LFSR. Two modes:
//   - bank mode: fills a flat seed register, LANES samples per cycle.
//   - stream mode: emits samples over a valid/ready stream.

---
 rtl/seed_lfsr_stream_bank.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seed_lfsr_stream_bank.sv
// seed_lfsr_stream_bank
//   Deterministic latent-seed source. A programmable-tap Fibonacci LFSR
//   produces Q8.8 samples (optionally arithmetic-shifted down). A run is
//   started from the stored seed register. It either fills a flat bank
//   register (LANES samples per clock) or emits the same sample sequence
//   over a valid/ready stream (LANES samples per beat).
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   start      begin a run (idle only); mode is sampled with it
//   abort      cancel the current run (no done pulse)
//   mode       0 = bank fill, 1 = stream
//   seed_load  load seed_in into the seed register (idle only; 0 -> default)
//   seed_in    new seed value
//   busy       run in progress
//   done       one-cycle pulse at run completion
//   seed_flat  sample bank, sample n at [n*DATA_WIDTH +: DATA_WIDTH]
//   s_valid    stream beat valid
//   s_ready    stream beat accepted
//   s_data     stream beat, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_last     final beat of the run
//   s_index    beat number within the run
module seed_lfsr_stream_bank #(
  parameter int                    SEED_COUNT   = 64,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] TAP_MASK     = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int                    LANES        = 1,
  parameter int                    SCALE_SHIFT  = 0,
  localparam int                   BEATS        = SEED_COUNT / LANES,
  localparam int                   IDX_W        = $clog2(BEATS) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             mode,
  input  logic                             seed_load,
  input  logic [LFSR_WIDTH-1:0]            seed_in,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat,
  output logic                             s_valid,
  input  logic                             s_ready,
  output logic [DATA_WIDTH*LANES-1:0]      s_data,
  output logic                             s_last,
  output logic [IDX_W-1:0]                 s_index
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BANK   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [LFSR_WIDTH-1:0]            seed_q, seed_d;
  logic [LFSR_WIDTH-1:0]            lfsr_q, lfsr_d;
  logic [IDX_W-1:0]                 beat_q, beat_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             s_valid_q, s_valid_d;
  logic [DATA_WIDTH*SEED_COUNT-1:0] flat_q, flat_d;

  // chain[k] is the LFSR state k steps after the current beat state.
  logic [LFSR_WIDTH-1:0]            chain [LANES+1];
  logic [DATA_WIDTH*LANES-1:0]      lane_data;
  logic                             last_beat;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & TAP_MASK)};
  endfunction

  assign chain[0] = lfsr_q;

  // Unrolled step chain: one beat covers LANES consecutive LFSR states, so
  // the sample order is the same for any lane count.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign chain[gi+1] = lfsr_step(chain[gi]);
      assign lane_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        $signed(chain[gi][DATA_WIDTH-1:0]) >>> SCALE_SHIFT;
    end
  endgenerate

  assign last_beat = (beat_q == IDX_W'(BEATS - 1));

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    lfsr_d    = lfsr_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_valid_d = s_valid_q;
    flat_d    = flat_q;

    case (state_q)
      IDLE: begin
        if (seed_load) begin
          seed_d = (seed_in == '0) ? DEFAULT_SEED : seed_in;
        end
        // The run takes seed_q, so a same-cycle seed_load only affects later runs.
        if (start && !abort) begin
          lfsr_d = seed_q;
          beat_d = '0;
          busy_d = 1'b1;
          if (mode) begin
            state_d   = STREAM;
            s_valid_d = 1'b1;
          end else begin
            state_d = BANK;
          end
        end
      end

      BANK: begin
        if (abort) begin
          // Nothing is written on the abort edge; earlier words stay as they are.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          for (int n = 0; n < SEED_COUNT; n++) begin
            if (beat_q == IDX_W'(n / LANES)) begin
              flat_d[n*DATA_WIDTH +: DATA_WIDTH] =
                lane_data[(n % LANES)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          lfsr_d = chain[LANES];
          beat_d = beat_q + IDX_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      STREAM: begin
        if (abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          s_valid_d = 1'b0;
        end else if (s_ready) begin
          if (last_beat) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            s_valid_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            lfsr_d = chain[LANES];
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seed_q    <= DEFAULT_SEED;
      lfsr_q    <= DEFAULT_SEED;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_valid_q <= 1'b0;
      flat_q    <= '0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      lfsr_q    <= lfsr_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_valid_q <= s_valid_d;
      flat_q    <= flat_d;
    end
  end

  // Stream outputs are derived from the registered beat state and forced to
  // zero whenever no beat is being offered.
  assign busy      = busy_q;
  assign done      = done_q;
  assign seed_flat = flat_q;
  assign s_valid   = s_valid_q;
  assign s_data    = s_valid_q ? lane_data : '0;
  assign s_last    = s_valid_q & last_beat;
  assign s_index   = s_valid_q ? beat_q : '0;

endmodule
